// File: rtl/simp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simp_pkg
//  Description : Shared types and constants for the SimpRisc fetch stage.
//                Holds the data width, the default reset PC, the fetch FSM
//                state encoding and the {pc, instr} fetch-buffer entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package simp_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/simp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : simp_fifo
//  Description : Small synchronous FIFO with flush. The head entry is read
//                straight from storage so the consumer sees it with zero
//                latency. Flush takes priority over push and pop.
//  Ports       : clk, reset (async, active-high)
//                push/push_data  - write one entry
//                pop             - drop the head entry (ignored when empty)
//                flush           - discard all entries
//                count/head/empty/full - occupancy and head entry
//  Revision    : 1.0 - initial release
// ============================================================================
module simp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign count    = r_count;
    assign head     = r_mem[r_rd_ptr];
    assign w_do_pop = pop & ~empty;

    // Storage is reset too, so the head output reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/simp_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : simp_fetch
//  Description : SimpRisc instruction fetch stage. Owns the PC, issues one
//                instruction read at a time to the memory port, buffers the
//                returned words and hands {pc, instr} pairs to decode.
//                Redirects flush the buffer and cancel any read in flight.
//  Ports       : clk, reset (async, active-high)
//                imem_req/imem_addr/imem_gnt      - read request channel
//                imem_rvalid/imem_rdata           - in-order read return
//                redirect_valid/redirect_pc       - control-flow redirect
//                out_valid/out_ready/out_pc/out_instr - decode handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module simp_fetch
    import simp_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        w_fetch_pc_nxt;
    logic [31:0]        r_req_pc;
    logic               r_outstanding;
    logic               w_outstanding_nxt;
    logic               r_kill;
    logic               w_kill_nxt;
    logic               w_fire;
    logic               w_push;
    logic               w_credit_ok;
    logic [31:0]        w_redirect_tgt;
    logic [c_cnt_w-1:0] w_count;
    logic               w_empty;
    logic               w_full;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;
    logic [63:0]        w_head_bits;

    assign w_redirect_tgt = redirect_pc & ~32'd3;

    // A read may only be issued if a buffer slot is reserved for it,
    // counting the read already in flight.
    assign w_credit_ok = (int'(w_count) + int'(r_outstanding)) < FIFO_DEPTH;

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_outstanding_nxt = r_outstanding;
        w_kill_nxt        = r_kill;
        imem_req          = 1'b0;
        w_fire            = 1'b0;
        w_push            = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
            end
            REQ: begin
                imem_req = w_credit_ok;
                w_fire   = w_credit_ok & imem_gnt;
                if (w_fire) begin
                    w_fetch_pc_nxt    = r_fetch_pc + 32'd4;
                    w_outstanding_nxt = 1'b1;
                    // A grant alongside a redirect still returns data,
                    // which must then be discarded.
                    w_kill_nxt        = redirect_valid;
                    w_state_nxt       = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_push            = ~r_kill & ~redirect_valid;
                    w_outstanding_nxt = 1'b0;
                    w_kill_nxt        = 1'b0;
                    w_state_nxt       = REQ;
                end else if (redirect_valid) begin
                    w_kill_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (redirect_valid) begin
            w_fetch_pc_nxt = w_redirect_tgt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_kill        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_kill        <= w_kill_nxt;
            if (w_fire) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    assign imem_addr          = r_fetch_pc;
    assign w_push_entry.pc    = r_req_pc;
    assign w_push_entry.instr = imem_rdata;

    simp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (out_ready),
        .flush     (redirect_valid),
        .count     (w_count),
        .head      (w_head_bits),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign w_head    = w_head_bits;
    assign out_valid = ~w_empty;
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_full));

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> r_outstanding);

endmodule
`default_nettype wire

// File: tb/tb_simp_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simp_fetch
//  Description : Scoreboard bench for simp_fetch. A memory model answers
//                reads; the expected instruction stream is derived from the
//                PC sequence (reset PC or redirect target, +4 per grant) and
//                checked by an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simp_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    simp_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t        exp_q[$];
    logic [31:0] model_pc = RST_PC;
    int          fire_cnt = 0;
    int          pop_cnt  = 0;
    logic [31:0] fire_addr_q[$];
    logic [31:0] pop_pc_q[$];
    int          pop_cyc_q[$];
    bit          stall_prev = 0;
    bit          redir_prev = 0;
    logic [31:0] addr_prev  = '0;

    bit          mem_pending = 0;
    int          mem_wait    = 0;
    logic [31:0] mem_data    = '0;

    int          gnt_pct   = 100;
    int          ready_pct = 100;
    int          redir_pm  = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    bit          redir_req = 0;
    logic [31:0] redir_tgt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input driver and memory responder: inputs change 1 ns after each rising edge.
    initial begin
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0;
                mem_pending = 0;
            end else begin
                imem_gnt    = ($urandom_range(99) < gnt_pct);
                out_ready   = ($urandom_range(99) < ready_pct);
                imem_rvalid = 0;
                imem_rdata  = $urandom();
                if (mem_pending) begin
                    if (mem_wait == 0) begin
                        imem_rvalid = 1;
                        imem_rdata  = mem_data;
                        mem_pending = 0;
                    end else begin
                        mem_wait--;
                    end
                end
                redirect_valid = 0;
                if (redir_req) begin
                    redirect_valid = 1;
                    redirect_pc    = redir_tgt;
                    redir_req      = 0;
                end else if ($urandom_range(999) < redir_pm) begin
                    redirect_valid = 1;
                    redirect_pc    = $urandom();
                end
            end
        end
    end

    // Stimulus-side scoreboard: each grant enqueues the instruction expected
    // for the next PC in sequence; a redirect discards everything in flight.
    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (stall_prev && !redir_prev) begin
                    check("req_hold", 32'(imem_req), 32'd1);
                    check("addr_hold", imem_addr, addr_prev);
                end
                if (imem_req) check("credit", 32'(exp_q.size() < DEPTH), 32'd1);
                fire = imem_req && imem_gnt;
                if (fire) begin
                    check("req_addr", imem_addr, model_pc);
                    fire_cnt++;
                    fire_addr_q.push_back(imem_addr);
                    mem_pending = 1;
                    mem_wait    = int'($urandom_range(lat_max, lat_min)) - 1;
                    mem_data    = instr_of(imem_addr);
                    if (!redirect_valid) exp_q.push_back('{pc: model_pc, instr: instr_of(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    model_pc = redirect_pc & ~32'd3;
                end
                stall_prev = imem_req && !imem_gnt;
                addr_prev  = imem_addr;
                redir_prev = redirect_valid;
            end
        end
    end

    // Output monitor: compares every accepted output against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (!reset && out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got pc %h, expected no output (cycle %0d)", out_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                end
                pop_cnt++;
                pop_pc_q.push_back(out_pc);
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1;
        exp_q.delete();
        model_pc = RST_PC; mem_pending = 0; redir_req = 0;
        stall_prev = 0; redir_prev = 0; fire_cnt = 0; pop_cnt = 0;
        fire_addr_q.delete(); pop_pc_q.delete(); pop_cyc_q.delete();
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 0;
    endtask

    task automatic step();
        @(negedge clk); #3;
    endtask

    initial begin
        int p;
        int idx;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int idx;
        // Zero-wait memory, decode always ready.
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1; redir_pm = 0;
        do_reset();
        step();
        check("idle_no_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 50 && pop_cnt < 3; i++) step();
        check("p1_pops", 32'(pop_cnt >= 3), 32'd1);
        if (pop_cnt >= 3) begin
            check("p1_addr0", fire_addr_q[0], 32'h8000_0000);
            check("p1_addr1", fire_addr_q[1], 32'h8000_0004);
            check("p1_addr2", fire_addr_q[2], 32'h8000_0008);
            check("p1_pc2", pop_pc_q[2], 32'h8000_0008);
            check("p1_gap1", 32'(pop_cyc_q[1] - pop_cyc_q[0]), 32'd2);
            check("p1_gap2", 32'(pop_cyc_q[2] - pop_cyc_q[1]), 32'd2);
        end

        // Decode stalled: exactly two grants fill the buffer.
        ready_pct = 0;
        do_reset();
        repeat (12) step();
        check("p2_grants", 32'(fire_cnt), 32'd2);
        check("p2_req_off", 32'(imem_req), 32'd0);
        check("p2_valid", 32'(out_valid), 32'd1);
        ready_pct = 100;
        for (int i = 0; i < 20 && fire_cnt < 3; i++) step();
        check("p2_resume", 32'(fire_cnt >= 3), 32'd1);
        if (fire_cnt >= 3) check("p2_resume_addr", fire_addr_q[2], 32'h8000_0008);

        // Grant withheld: request and address must hold.
        gnt_pct = 0;
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("p3_req", 32'(imem_req), 32'd1);
            check("p3_addr", imem_addr, RST_PC);
        end
        check("p3_nogrant", 32'(fire_cnt), 32'd0);

        // Redirect while a slow read is outstanding.
        gnt_pct = 100; lat_min = 5; lat_max = 5;
        do_reset();
        for (int i = 0; i < 40 && fire_cnt < 2; i++) step();
        p = pop_cnt;
        redir_tgt = 32'h8000_0103; redir_req = 1;
        for (int i = 0; i < 40 && (fire_cnt < 3 || pop_cnt <= p); i++) step();
        check("p4_progress", 32'(fire_cnt >= 3 && pop_cnt > p), 32'd1);
        if (fire_cnt >= 3 && pop_cnt > p) begin
            check("p4_next_addr", fire_addr_q[2], 32'h8000_0100);
            check("p4_next_pc", pop_pc_q[p], 32'h8000_0100);
        end

        // Redirect on a full buffer with decode ready in the same cycle.
        lat_min = 1; lat_max = 1; ready_pct = 0;
        do_reset();
        repeat (12) step();
        check("p5_full_valid", 32'(out_valid), 32'd1);
        ready_pct = 100; redir_tgt = 32'h0000_1000; redir_req = 1;
        p = pop_cnt;
        step();
        step();
        check("p5_no_pop", 32'(pop_cnt), 32'(p));
        check("p5_flushed", 32'(out_valid), 32'd0);

        // Address wrap at the top of the address space.
        redir_tgt = 32'hFFFF_FFFC; redir_req = 1;
        p = fire_cnt;
        repeat (20) step();
        idx = -1;
        for (int i = p; i < fire_addr_q.size(); i++)
            if (idx < 0 && fire_addr_q[i] == 32'hFFFF_FFFC) idx = i;
        check("p6_wrap_seen", 32'(idx >= 0 && idx + 1 < fire_addr_q.size()), 32'd1);
        if (idx >= 0 && idx + 1 < fire_addr_q.size())
            check("p6_wrap_addr", fire_addr_q[idx + 1], 32'h0000_0000);

        // Reset in the middle of a read.
        lat_min = 6; lat_max = 6;
        for (int i = 0; i < 30 && !(mem_pending && mem_wait >= 3); i++) step();
        check("p6_wait_seen", 32'(mem_pending && mem_wait >= 3), 32'd1);
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20 && fire_cnt < 1; i++) step();
        check("p6_restart", 32'(fire_cnt >= 1), 32'd1);
        if (fire_cnt >= 1) check("p6_restart_addr", fire_addr_q[0], RST_PC);

        // Randomized traffic.
        for (int b = 0; b < 8; b++) begin
            gnt_pct   = int'($urandom_range(100, 30));
            ready_pct = int'($urandom_range(100, 20));
            lat_min   = 1;
            lat_max   = int'($urandom_range(4, 1));
            redir_pm  = int'($urandom_range(40, 0));
            repeat (400) step();
        end

        // Drain: stop new grants and let decode empty the buffer.
        redir_pm = 0; gnt_pct = 0; ready_pct = 100;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || mem_pending); i++) step();
        check("drain_done", 32'(exp_q.size() == 0 && !mem_pending), 32'd1);
        repeat (3) step();
        check("drain_idle", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simp_fetch.md
Name: simp_fetch

Overview:
- Instruction fetch stage of the SimpRisc core. Sits directly upstream of the unified memory port: it owns the PC, issues instruction reads, and receives the returned instruction words.
- Buffers fetched words in a small FIFO and presents {pc, instruction} pairs to decode with a valid/ready handshake.
- Handles control-flow redirects from execute, including discarding a read that is already in flight.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  read request valid to memory
imem_addr  output  32  word-aligned fetch address
imem_gnt  input  1  memory accepts request this cycle (imem_req & imem_gnt)
imem_rvalid  input  1  read data valid; arrives >=1 cycle after grant, in order
imem_rdata  input  32  returned instruction word
redirect_valid  input  1  branch/jump taken, one-cycle pulse
redirect_pc  input  32  new fetch target (bits[1:0] ignored, forced 0)
out_valid  output  1  FIFO head valid to decode
out_ready  input  1  decode accepts head
out_pc  output  32  PC of head instruction
out_instr  output  32  head instruction word

Behaviour:
- Reset (async assert, sync-safe deassert):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; kill=0; state=IDLE.
  - Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
- At most one outstanding read. States:
  - IDLE: the cycle after reset deassert, move to REQ. No request is issued in IDLE.
  - REQ: imem_req=1 when credits>0, where credits = FIFO_DEPTH - count - outstanding. imem_addr=fetch_pc. On grant: fetch_pc+=4 (wraps modulo 2^32), outstanding=1, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: if kill=0, push {req_pc, imem_rdata}; clear outstanding and kill; go to REQ.
- req_pc: latched at grant, so the pushed pc is the address actually requested.
- Minimum grant-to-push latency is 1 cycle; FIFO-to-output latency is 0 (out_* driven from the head register). Peak throughput is 1 instruction per 2 cycles with single-cycle memory.
- Pop: out_valid & out_ready. Push and pop in the same cycle on a full FIFO is legal only because credits prevent overfill; a push never occurs when full (assertion).
- Redirect (highest priority, takes effect at that clock edge):
  - FIFO flushed (count=0, out_valid=0 next cycle); fetch_pc=redirect_pc & ~3.
  - If a read is outstanding, or imem_rvalid is high in the same cycle, that data is dropped. Outstanding read: set kill=1, stay in WAIT. Otherwise go to REQ.
  - A request granted in the same cycle as redirect: grant is honoured (memory returns data), kill=1, fetch_pc=redirect target (not +4).
  - A pop in the same cycle as redirect is ignored (flush wins).
- imem_addr/imem_req stable while imem_req=1 and imem_gnt=0, unless redirect (request may then change address).
- Reset mid-operation: all state cleared immediately. A late imem_rvalid after reset with outstanding=0 is ignored (assertion flags it).

Decomposition:
- Package simp_pkg: XLEN=32, RESET_PC default, fetch_state_e {IDLE, REQ, WAIT}, typedef fetch_entry_t {pc, instr}.
- Sub-module simp_fifo (parameterised depth/width, push/pop/flush, count, head output) instantiated once.
- The FSM, credit, and kill logic stay in simp_fetch.

Test Plan:
- Reset then zero-wait memory (grant same cycle, rvalid next cycle) with out_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008; outputs appear in order with matching pc, one per 2 cycles.
- out_ready=0 with FIFO_DEPTH=2 -> exactly 2 grants; imem_req stays 0 until a pop; then resumes at 0x80000008.
- imem_gnt held 0 for 3 cycles -> imem_req=1 and imem_addr=0x80000000 stable; fetch_pc unchanged.
- Redirect to 0x80000103 while a read for 0x80000004 is outstanding (rvalid 4 cycles later) -> returned word dropped, FIFO empty, next request addr=0x80000100, next out_pc=0x80000100.
- Redirect with FIFO full and out_ready=1 the same cycle -> no pop recorded, out_valid=0 next cycle, stale entries never emitted.
- Fetch at 0xFFFFFFFC -> next address wraps to 0x00000000; assert reset mid-WAIT -> outputs return to reset values asynchronously, restart at RESET_PC.
